// File: rtl/pattern_rom_arbiter.sv
// pattern_rom_arbiter: shares one synchronous pattern/envelope ROM between
// NUM_REQ requesters. IDLE -> READ -> CAPTURE, one read per three cycles,
// one-hot o_valid pulse alongside the registered o_data word.
// Arbitration is round-robin by default. Defining the macro
// PATTERN_ROM_ARB_FIXED_PRIORITY_EN switches to lowest-index-wins, and the
// priority pointer then stays at zero.
module pattern_rom_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
    output logic [NUM_REQ-1:0]            o_valid,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic [ADDR_WIDTH-1:0]         o_rom_addr,
    input  logic [DATA_WIDTH-1:0]         i_rom_data,
    output logic                          o_busy
);

    localparam int IDX_WIDTH = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPTURE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [IDX_WIDTH-1:0]   r_winner;
    logic [IDX_WIDTH-1:0]   r_ptr;
    logic [NUM_REQ-1:0]     r_valid;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [ADDR_WIDTH-1:0]  r_rom_addr;

    logic [NUM_REQ-1:0]     w_eligible;
    logic [2*NUM_REQ-1:0]   w_rotated;
    logic                   w_found;
    logic [IDX_WIDTH-1:0]   w_win_idx;
    int                     w_offset;
    int                     w_sum;

    // A requester whose pulse is on o_valid this cycle sits out this round,
    // so a level request held through its pulse cannot win back-to-back.
    assign w_eligible = i_req & ~r_valid;

    // Rotate the eligible vector so that bit 0 is the requester at the pointer.
    assign w_rotated  = {w_eligible, w_eligible} >> r_ptr;

    // Winner selection: the first eligible index at or after the pointer.
    always_comb begin
        // NOTE: every variable gets a default first; a path that leaves one
        // unassigned in always_comb would infer a latch.
        w_found   = 1'b0;
        w_offset  = 0;
        w_sum     = 0;
        w_win_idx = '0;
`ifdef PATTERN_ROM_ARB_FIXED_PRIORITY_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_found  = 1'b1;
                w_offset = i;
            end
        end
        w_sum = w_offset;
`else
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rotated[i]) begin
                w_found  = 1'b1;
                w_offset = i;
            end
        end
        w_sum = int'(r_ptr) + w_offset;
        if (w_sum >= NUM_REQ) begin
            w_sum = w_sum - NUM_REQ;
        end
`endif
        w_win_idx = IDX_WIDTH'(w_sum);
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every flop samples pre-edge values regardless of statement order.
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_found) w_state_next = ST_READ;
            ST_READ:    w_state_next = ST_CAPTURE;
            ST_CAPTURE: w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: latch winner and address, capture ROM data, pulse o_valid,
    // advance the priority pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_winner   <= '0;
            r_ptr      <= '0;
            r_valid    <= '0;
            r_data     <= '0;
            r_rom_addr <= '0;
        end else begin
            r_valid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_winner   <= w_win_idx;
                        r_rom_addr <= i_addr[w_win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    end
                end
                ST_CAPTURE: begin
                    r_data  <= i_rom_data;
                    r_valid <= NUM_REQ'(1) << r_winner;
`ifdef PATTERN_ROM_ARB_FIXED_PRIORITY_EN
                    r_ptr   <= '0;
`else
                    if (r_winner == IDX_WIDTH'(NUM_REQ - 1)) begin
                        r_ptr <= '0;
                    end else begin
                        r_ptr <= r_winner + 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_rom_addr = r_rom_addr;
    assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pattern_rom_arbiter.sv
// Self-checking bench for pattern_rom_arbiter (NUM_REQ=4). A behavioural
// rom_sync with a fixed content function feeds the DUT; expected winners and
// data are hand-computed in the vector table and sequences below.
module tb_pattern_rom_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 16;

    logic                          i_clk;
    logic                          i_rst_n;
    logic [NUM_REQ-1:0]            i_req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr;
    logic [NUM_REQ-1:0]            o_valid;
    logic [DATA_WIDTH-1:0]         o_data;
    logic [ADDR_WIDTH-1:0]         o_rom_addr;
    logic [DATA_WIDTH-1:0]         i_rom_data;
    logic                          o_busy;

    int n_tests = 0;
    int n_fail  = 0;

    pattern_rom_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .o_rom_addr(o_rom_addr),
        .i_rom_data(i_rom_data),
        .o_busy    (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ROM content: 0x10 holds 16'hABCD, every other word is {addr^0x5A, addr}.
    function automatic logic [15:0] rom_model(input logic [7:0] a);
        if (a == 8'h10) return 16'hABCD;
        return {a ^ 8'h5A, a};
    endfunction

    // rom_sync: one-cycle registered read.
    always @(posedge i_clk) i_rom_data <= rom_model(o_rom_addr);

    // Default per-requester addresses: 0:0x10 1:0x20 2:0x40 3:0x80.
    localparam logic [31:0] ADDR_DEFAULT = {8'h80, 8'h40, 8'h20, 8'h10};

    function automatic logic [7:0] addr_of(input int n);
        logic [31:0] bus;
        bus = ADDR_DEFAULT;
        return bus[n*8 +: 8];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; advances cycle by cycle until o_valid is seen at a
    // negedge or the budget runs out.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (o_valid == '0 && cycles < 12) begin
            @(posedge i_clk);
            @(negedge i_clk);
            cycles++;
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_req   = '0;
        i_rst_n = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    // Raise mask while idle, expect exp_win to be serviced after 3 cycles,
    // then drop all requests and confirm the pulse lasts one cycle.
    task automatic run_grant(input string name, input logic [3:0] mask, input int exp_win);
        int cycles;
        logic [15:0] exp_data;
        exp_data = rom_model(addr_of(exp_win));
        i_req = mask;
        wait_valid(cycles);
        check({name, "_latency"}, cycles, 3);
        check({name, "_valid"}, 32'(o_valid), 32'(4'b0001 << exp_win));
        check({name, "_data"}, 32'(o_data), 32'(exp_data));
        i_req = '0;
        @(negedge i_clk);
        check({name, "_pulse_end"}, 32'(o_valid), 0);
        check({name, "_data_hold"}, 32'(o_data), 32'(exp_data));
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Hold mask and record up to n pulses: index and cycle of each.
    task automatic collect(input logic [3:0] mask, input int n,
                           output int idx[5], output int when[5], output int got);
        int cyc;
        got = 0;
        cyc = 0;
        i_req = mask;
        while (got < n && cyc < 40) begin
            @(posedge i_clk);
            @(negedge i_clk);
            cyc++;
            if (o_valid != '0) begin
                check("onehot", 32'($countones(o_valid)), 1);
                idx[got]  = onehot_idx(o_valid);
                when[got] = cyc;
                got++;
            end
        end
        i_req = '0;
        repeat (4) @(negedge i_clk);
    endtask

    typedef struct {
        logic [3:0] req;
        int         exp_rr;
        int         exp_fixed;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int cycles;
        int idx[5];
        int when[5];
        int got;
        int pulses;
        int exp_order[5];

        i_rst_n = 1'b0;
        i_req   = '0;
        i_addr  = ADDR_DEFAULT;

        // Pointer sequence (round-robin) starting from p=1 after the first grant.
        vecs[0] = '{4'b0001, 0, 0};
        vecs[1] = '{4'b0001, 0, 0};
        vecs[2] = '{4'b1001, 3, 0};
        vecs[3] = '{4'b1100, 2, 2};
        vecs[4] = '{4'b0101, 0, 0};
        vecs[5] = '{4'b0110, 1, 1};
        vecs[6] = '{4'b1011, 3, 0};
        vecs[7] = '{4'b1111, 0, 0};
        vecs[8] = '{4'b1101, 2, 0};
        vecs[9] = '{4'b0010, 1, 1};

        // Reset state.
        #3;
        check("rst_valid", 32'(o_valid), 0);
        check("rst_data", 32'(o_data), 0);
        check("rst_rom_addr", 32'(o_rom_addr), 0);
        check("rst_busy", 32'(o_busy), 0);
        do_reset();

        // Single request from requester 0: address in READ, data after 3 cycles.
        i_req = 4'b0001;
        @(posedge i_clk);
        @(negedge i_clk);
        check("first_rom_addr", 32'(o_rom_addr), 32'h10);
        check("first_busy", 32'(o_busy), 1);
        wait_valid(cycles);
        check("first_latency", 32'(cycles + 1), 3);
        check("first_valid", 32'(o_valid), 32'h1);
        check("first_data", 32'(o_data), 32'hABCD);
        i_req = '0;
        @(negedge i_clk);
        check("first_pulse_end", 32'(o_valid), 0);
        check("first_idle", 32'(o_busy), 0);

        // Table of arbitration vectors.
        for (int v = 0; v < 10; v++) begin
`ifdef PATTERN_ROM_ARB_FIXED_PRIORITY_EN
            run_grant($sformatf("vec%0d", v), vecs[v].req, vecs[v].exp_fixed);
`else
            run_grant($sformatf("vec%0d", v), vecs[v].req, vecs[v].exp_rr);
`endif
        end

        // All four requesting continuously.
        do_reset();
`ifdef PATTERN_ROM_ARB_FIXED_PRIORITY_EN
        exp_order = '{0, 1, 0, 1, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        collect(4'b1111, 5, idx, when, got);
        check("all_count", 32'(got), 5);
        check("all_first_lat", 32'(when[0]), 3);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("all_order%0d", k), 32'(idx[k]), 32'(exp_order[k]));
            if (k > 0) check($sformatf("all_space%0d", k), 32'(when[k] - when[k-1]), 3);
        end

        // Requester 2 holds through its pulse while 3 also requests.
        do_reset();
        run_grant("mask_pre", 4'b0010, 1);
        collect(4'b1100, 2, idx, when, got);
        check("mask_count", 32'(got), 2);
        check("mask_first", 32'(idx[0]), 2);
        check("mask_second", 32'(idx[1]), 3);
        check("mask_space", 32'(when[1] - when[0]), 3);

        // Asynchronous reset during READ.
        do_reset();
        run_grant("arst_pre", 4'b0010, 1);
        i_req = 4'b1111;
        @(posedge i_clk);
        #2;
        check("arst_busy_before", 32'(o_busy), 1);
        i_rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(o_busy), 0);
        check("arst_valid", 32'(o_valid), 0);
        check("arst_rom_addr", 32'(o_rom_addr), 0);
        i_req = '0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge i_clk);
            if (o_valid != '0) pulses++;
        end
        check("arst_no_pulse", 32'(pulses), 0);
        run_grant("arst_restart", 4'b1111, 0);

        // Address change of the winner during READ does not affect the read.
        i_addr = ADDR_DEFAULT;
        i_req  = 4'b0010;
        @(posedge i_clk);
        @(negedge i_clk);
        i_addr[15:8] = 8'h30;
        wait_valid(cycles);
        check("addr_chg_valid", 32'(o_valid), 32'h2);
        check("addr_chg_data", 32'(o_data), 32'(rom_model(8'h20)));
        i_req  = '0;
        i_addr = ADDR_DEFAULT;
        repeat (3) @(negedge i_clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
